// File: rtl/sound_pkg.sv
// Sound ids, FSM states and melody tables shared by the speaker path.
package sound_pkg;

  // Encoding doubles as arbitration priority (higher value wins).
  typedef enum logic [1:0] {
    SND_NONE  = 2'd0,
    SND_CLICK = 2'd1,
    SND_SCORE = 2'd2,
    SND_OVER  = 2'd3
  } sound_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_GAP
  } state_t;

  localparam int unsigned MAX_NOTES  = 3;
  localparam int unsigned NOTE_IDX_W = $clog2(MAX_NOTES);
  localparam int unsigned NOTE_HP_W  = 4;
  localparam int unsigned TOG_W      = 3;

  typedef struct packed {
    logic [NOTE_HP_W-1:0] hp;
    logic [TOG_W-1:0]     toggles;
  } note_t;

  // Index of the final note of each melody.
  function automatic logic [NOTE_IDX_W-1:0] last_note(input sound_t snd);
    case (snd)
      SND_SCORE: return NOTE_IDX_W'(1);
      SND_OVER:  return NOTE_IDX_W'(2);
      default:   return NOTE_IDX_W'(0);
    endcase
  endfunction

  function automatic note_t note_lookup(input sound_t snd,
                                        input logic [NOTE_IDX_W-1:0] idx);
    note_t n;
    n = '{hp: '0, toggles: '0};
    case (snd)
      SND_CLICK: n = '{hp: 4'd4, toggles: 3'd6};
      SND_SCORE: begin
        case (idx)
          NOTE_IDX_W'(0): n = '{hp: 4'd3, toggles: 3'd4};
          default:        n = '{hp: 4'd2, toggles: 3'd4};
        endcase
      end
      SND_OVER: begin
        case (idx)
          NOTE_IDX_W'(0): n = '{hp: 4'd5, toggles: 3'd4};
          NOTE_IDX_W'(1): n = '{hp: 4'd6, toggles: 3'd4};
          default:        n = '{hp: 4'd8, toggles: 3'd6};
        endcase
      end
      default: n = '{hp: '0, toggles: '0};
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sound_player_tone_gen.sv
// Square-wave generator for one note: half-period counter, toggle counter
// and the speaker flop. Sequenced by sound_player.
module tone_gen
  import sound_pkg::*;
#(
  parameter int unsigned HP_SHIFT = 10,
  parameter int unsigned HP_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_ce,
  input  logic                 i_clear,
  input  logic                 i_run,
  input  logic [NOTE_HP_W-1:0] i_hp,
  input  logic [TOG_W-1:0]     i_toggles,
  output logic                 o_speaker,
  output logic                 o_note_done
);

  logic [HP_WIDTH-1:0] r_hp_cnt;
  logic [TOG_W-1:0]    r_tog_cnt;
  logic                r_speaker;
  logic [HP_WIDTH-1:0] w_hp_last;
  logic                w_wrap;
  logic                w_step;

  assign w_hp_last   = (HP_WIDTH'(i_hp) << HP_SHIFT) - HP_WIDTH'(1);
  assign w_wrap      = (r_hp_cnt == w_hp_last);
  assign w_step      = i_ce & i_run & ~i_clear;
  assign o_note_done = w_step & w_wrap & ((r_tog_cnt + TOG_W'(1)) == i_toggles);
  assign o_speaker   = r_speaker;

  // Count half-periods and toggle the speaker at each wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hp_cnt  <= '0;
      r_tog_cnt <= '0;
      r_speaker <= 1'b0;
    end else if (i_ce) begin
      if (i_clear) begin
        r_hp_cnt  <= '0;
        r_tog_cnt <= '0;
        r_speaker <= 1'b0;
      end else if (i_run) begin
        if (w_wrap) begin
          r_hp_cnt  <= '0;
          r_speaker <= ~r_speaker;
          r_tog_cnt <= r_tog_cnt + TOG_W'(1);
        end else begin
          r_hp_cnt <= r_hp_cnt + HP_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/sound_player.sv
// Turns one-cycle game events into short square-wave melodies on the
// speaker pin, with priority preemption between events.
module sound_player
  import sound_pkg::*;
#(
  parameter int unsigned HP_SHIFT   = 10,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned HP_WIDTH   = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   ce,
  input  logic   click_req,
  input  logic   score_req,
  input  logic   over_req,
  output logic   speaker,
  output logic   busy,
  output sound_t sound
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t                r_state,    w_state_nxt;
  sound_t                r_sound,    w_sound_nxt;
  logic [NOTE_IDX_W-1:0] r_note_idx, w_note_idx_nxt;
  logic [GAP_W-1:0]      r_gap_cnt,  w_gap_cnt_nxt;

  sound_t w_req;
  logic   w_accept;
  note_t  w_note;
  logic   w_note_done;
  logic   w_tg_clear;
  logic   w_tg_run;

  // Pick the highest pending request and decide whether it may preempt.
  always_comb begin
    w_req = SND_NONE;
    if (over_req)       w_req = SND_OVER;
    else if (score_req) w_req = SND_SCORE;
    else if (click_req) w_req = SND_CLICK;
    w_accept = ce && (w_req != SND_NONE) &&
               ((r_state == ST_IDLE) || (w_req >= r_sound));
  end

  assign w_note     = note_lookup(r_sound, r_note_idx);
  assign w_tg_run   = (r_state == ST_PLAY);
  // Tone counters stay cleared outside PLAY, so GAP and IDLE need no extra reset.
  assign w_tg_clear = w_accept | (r_state != ST_PLAY);

  tone_gen #(
    .HP_SHIFT (HP_SHIFT),
    .HP_WIDTH (HP_WIDTH)
  ) u_tone_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_ce        (ce),
    .i_clear     (w_tg_clear),
    .i_run       (w_tg_run),
    .i_hp        (w_note.hp),
    .i_toggles   (w_note.toggles),
    .o_speaker   (speaker),
    .o_note_done (w_note_done)
  );

  // Melody sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_sound    <= SND_NONE;
      r_note_idx <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_sound    <= w_sound_nxt;
      r_note_idx <= w_note_idx_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
    end
  end

  // Next-state logic; acceptance overrides same-tick note-end and gap-end.
  always_comb begin
    w_state_nxt    = r_state;
    w_sound_nxt    = r_sound;
    w_note_idx_nxt = r_note_idx;
    w_gap_cnt_nxt  = r_gap_cnt;
    if (w_accept) begin
      w_state_nxt    = ST_PLAY;
      w_sound_nxt    = w_req;
      w_note_idx_nxt = '0;
      w_gap_cnt_nxt  = '0;
    end else if (ce) begin
      case (r_state)
        ST_PLAY: begin
          if (w_note_done) begin
            w_gap_cnt_nxt = '0;
            if (r_note_idx == last_note(r_sound)) begin
              w_state_nxt    = ST_IDLE;
              w_sound_nxt    = SND_NONE;
              w_note_idx_nxt = '0;
            end else begin
              w_state_nxt = ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            w_state_nxt    = ST_PLAY;
            w_note_idx_nxt = r_note_idx + NOTE_IDX_W'(1);
            w_gap_cnt_nxt  = '0;
          end else begin
            w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (r_state != ST_IDLE);
  assign sound = r_sound;

endmodule

// File: tb/tb_sound_player.sv
// Directed and random stimulus against a queue-based waveform model.
module tb_sound_player;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ce;
  logic       click_req;
  logic       score_req;
  logic       over_req;
  logic       speaker;
  logic       busy;
  logic [1:0] sound;

  always #5 clk = ~clk;

  sound_player #(
    .HP_SHIFT   (0),
    .GAP_CYCLES (2),
    .HP_WIDTH   (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .click_req (click_req),
    .score_req (score_req),
    .over_req  (over_req),
    .speaker   (speaker),
    .busy      (busy),
    .sound     (sound)
  );

  localparam int GAP = 2;

  // Melody tables indexed by sound id, then note.
  int hp_tab[4][3] = '{'{0, 0, 0}, '{4, 0, 0}, '{3, 2, 0}, '{5, 6, 8}};
  int tg_tab[4][3] = '{'{0, 0, 0}, '{6, 0, 0}, '{4, 4, 0}, '{4, 4, 6}};
  int n_tab[4]     = '{0, 1, 2, 3};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Expected {sound, busy, speaker} after each upcoming ce edge.
  int         exp_q[$];
  logic [3:0] exp_now = 4'd0;

  function automatic int enc(int s, int b, int sp);
    return s * 4 + b * 2 + sp;
  endfunction

  // Expand a whole melody into its per-ce-tick output sequence.
  task automatic build(input int s);
    int level;
    exp_q.delete();
    exp_q.push_back(enc(s, 1, 0));
    for (int i = 0; i < n_tab[s]; i++) begin
      level = 0;
      if (i > 0)
        for (int g = 0; g < GAP; g++) exp_q.push_back(enc(s, 1, 0));
      for (int j = 0; j < tg_tab[s][i]; j++) begin
        for (int k = 0; k < hp_tab[s][i] - 1; k++) exp_q.push_back(enc(s, 1, level));
        level = 1 - level;
        exp_q.push_back(enc(s, 1, level));
      end
    end
    exp_q[exp_q.size() - 1] = enc(0, 0, 0);
  endtask

  task automatic model_edge(input logic c, input logic s, input logic o);
    int req;
    req = o ? 3 : (s ? 2 : (c ? 1 : 0));
    if (req != 0 && req >= int'(exp_now[3:2])) build(req);
    if (exp_q.size() > 0) exp_now = 4'(exp_q.pop_front());
    else                  exp_now = 4'd0;
  endtask

  task automatic check(input string tag);
    total++;
    assert ({sound, busy, speaker} === exp_now) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed(snd,busy,spk)=%b expected=%b",
             tag, cyc, {sound, busy, speaker}, exp_now);
    end
  endtask

  task automatic tick(input logic e, input logic c, input logic s,
                      input logic o, input string tag);
    ce        = e;
    click_req = c;
    score_req = s;
    over_req  = o;
    @(posedge clk);
    cyc++;
    if (e) model_edge(c, s, o);
    #1;
    check(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    ce        = 1'b0;
    click_req = 1'b0;
    score_req = 1'b0;
    over_req  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_now = 4'd0;
    check("reset");
    rst_n = 1'b1;

    tick(1'b1, 1'b1, 1'b0, 1'b0, "click");
    idle(30, "click");

    tick(1'b1, 1'b0, 1'b1, 1'b0, "score");
    idle(30, "score");

    tick(1'b1, 1'b1, 1'b0, 1'b0, "pre_click");
    idle(5, "pre_click");
    tick(1'b1, 1'b0, 1'b0, 1'b1, "pre_over");
    idle(8, "pre_over");
    tick(1'b1, 1'b1, 1'b0, 1'b0, "over_ign_click");
    idle(70, "over_run");

    tick(1'b1, 1'b1, 1'b1, 1'b0, "simul");
    idle(7, "simul");
    tick(1'b1, 1'b0, 1'b1, 1'b0, "score_restart");
    idle(30, "score_restart");

    tick(1'b1, 1'b1, 1'b0, 1'b0, "thr_click");
    for (int k = 0; k < 30; k++) begin
      tick(1'b0, 1'b0, 1'b0, (k == 4), "thr_ce0");
      tick(1'b0, 1'b0, 1'b0, 1'b0, "thr_ce0");
      tick(1'b1, 1'b0, 1'b0, 1'b0, "thr_ce1");
    end
    idle(5, "thr_tail");

    tick(1'b1, 1'b1, 1'b0, 1'b0, "rst_click");
    idle(5, "rst_click");
    total++;
    assert (speaker === 1'b1) else begin
      bad++;
      $error("FAIL pre_rst_speaker observed=%b expected=1", speaker);
    end
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_now = 4'd0;
    check("async_rst");
    #3;
    rst_n = 1'b1;
    tick(1'b1, 1'b1, 1'b0, 1'b0, "post_rst_click");
    idle(30, "post_rst_click");

    for (int i = 0; i < 800; i++) begin
      int r;
      r = int'($urandom_range(23, 0));
      tick(($urandom_range(3, 0) != 0), (r == 0 || r == 3), (r == 1 || r == 3),
           (r == 2 || r == 3), "random");
    end
    idle(80, "drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
